// File: rtl/cx_pkg.sv
// cx_pkg: shared CX widths, CXU function codes, status flags, FSM states.
// Imported by every cxu_mac file.
package cx_pkg;

  localparam int CX_DATA_W     = 32;
  localparam int CX_STATUS_W   = 4;
  localparam int CX_STATE_ID_W = 2;
  localparam int CX_FUNC_W     = 3;

  localparam logic [2:0] CXU_MUL   = 3'd0;
  localparam logic [2:0] CXU_MAC   = 3'd1;
  localparam logic [2:0] CXU_READ  = 3'd2;
  localparam logic [2:0] CXU_WRITE = 3'd3;
  localparam logic [2:0] CXU_CLEAR = 3'd4;

  localparam logic [3:0] ST_ILLEGAL = 4'b0001;
  localparam logic [3:0] ST_CARRY   = 4'b0010;
  localparam logic [3:0] ST_MUL_OVF = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_REPLY
  } cxu_state_e;

endpackage

// File: rtl/cxu_mac_if.sv
// cxu_mac_if: switch <-> CXU request/reply bundle.
// master = switch side (drives request), slave = CXU side (drives reply).
interface cxu_mac_if;
  import cx_pkg::*;

  logic                     req_start_i;
  logic [CX_FUNC_W-1:0]     func_i;
  logic [CX_STATE_ID_W-1:0] state_id_i;
  logic [CX_DATA_W-1:0]     data0_i;
  logic [CX_DATA_W-1:0]     data1_i;
  logic                     replying_o;
  logic [CX_DATA_W-1:0]     response_o;
  logic [CX_STATUS_W-1:0]   status_o;
  logic                     busy_o;

  modport master (
    output req_start_i, func_i, state_id_i, data0_i, data1_i,
    input  replying_o, response_o, status_o, busy_o
  );

  modport slave (
    input  req_start_i, func_i, state_id_i, data0_i, data1_i,
    output replying_o, response_o, status_o, busy_o
  );

endinterface

// File: rtl/cxu_mac_mulseq.sv
// cxu_mac_mulseq: iterative shift-add multiplier, one bit per step.
// start loads a/b; step advances; done/product/ovf describe the current step.
module cxu_mac_mulseq #(
  parameter bit EARLY_TERM = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        step,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        done,
  output logic [31:0] product,
  output logic        ovf
);
  import cx_pkg::*;

  logic [31:0] mcand_q;
  logic [31:0] mplier_q;
  logic [31:0] prod_q;
  logic        ovf_q;
  logic [4:0]  cnt_q;
  logic [32:0] add;
  logic        rest_nz;
  logic        lost;

  // A set mcand bit shifted out only matters if a later
  // multiplier bit would still have added it in.
  always_comb begin
    rest_nz = (mplier_q[31:1] != 31'd0);
    lost    = mcand_q[31] & rest_nz;
    add     = {1'b0, prod_q};
    if (mplier_q[0]) add = {1'b0, prod_q} + {1'b0, mcand_q};
    product = add[31:0];
    ovf     = ovf_q | add[32] | lost;
    done    = step & (EARLY_TERM ? !rest_nz : (cnt_q == 5'd31));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (start) begin
      mcand_q  <= a;
      mplier_q <= b;
      prod_q   <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (step) begin
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      prod_q   <= product;
      ovf_q    <= ovf;
      cnt_q    <= cnt_q + 5'd1;
    end
  end

endmodule

// File: rtl/cxu_mac.sv
// cxu_mac: stateful CXU with per-context accumulators, MUL/MAC/READ/WRITE/CLEAR.
// Ports: clk, rst (sync, active-high), cx (cxu_mac_if.slave request/reply).
module cxu_mac #(
  parameter int N_STATES   = 4,
  parameter bit EARLY_TERM = 1'b1
) (
  input logic   clk,
  input logic   rst,
  cxu_mac_if.slave cx
);
  import cx_pkg::*;

  cxu_state_e  state_q;
  cxu_state_e  state_d;
  logic [2:0]  func_q;
  logic [1:0]  sid_q;
  logic [31:0] acc [N_STATES];
  logic [31:0] resp_q;
  logic [3:0]  stat_q;

  logic        is_mul;
  logic        mul_start;
  logic        mul_step;
  logic        mul_done;
  logic [31:0] mul_prod;
  logic        mul_ovf;
  logic [32:0] mac_sum;
  logic [3:0]  mul_stat;

  assign is_mul    = (cx.func_i == CXU_MUL) || (cx.func_i == CXU_MAC);
  assign mul_start = (state_q == S_IDLE) && cx.req_start_i && is_mul;
  assign mul_step  = (state_q == S_BUSY);

  cxu_mac_mulseq #(
    .EARLY_TERM(EARLY_TERM)
  ) u_mulseq (
    .clk    (clk),
    .rst    (rst),
    .start  (mul_start),
    .step   (mul_step),
    .a      (cx.data0_i),
    .b      (cx.data1_i),
    .done   (mul_done),
    .product(mul_prod),
    .ovf    (mul_ovf)
  );

  always_comb begin
    mac_sum  = {1'b0, acc[sid_q]} + {1'b0, mul_prod};
    mul_stat = mul_ovf ? ST_MUL_OVF : 4'b0000;
    if (func_q == CXU_MAC && mac_sum[32]) mul_stat = mul_stat | ST_CARRY;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (cx.req_start_i) state_d = is_mul ? S_BUSY : S_REPLY;
      end
      S_BUSY: begin
        if (mul_done) state_d = S_REPLY;
      end
      S_REPLY: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cx.replying_o = (state_q == S_REPLY);
    cx.busy_o     = (state_q != S_IDLE);
    cx.response_o = resp_q;
    cx.status_o   = stat_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      func_q <= '0;
      sid_q  <= '0;
      resp_q <= '0;
      stat_q <= '0;
      for (int i = 0; i < N_STATES; i++) acc[i] <= '0;
    end else if (state_q == S_IDLE && cx.req_start_i) begin
      func_q <= cx.func_i;
      sid_q  <= cx.state_id_i;
      unique case (cx.func_i)
        CXU_MUL, CXU_MAC: ;
        CXU_READ: begin
          resp_q <= acc[cx.state_id_i];
          stat_q <= '0;
        end
        CXU_WRITE: begin
          resp_q <= acc[cx.state_id_i];
          stat_q <= '0;
          acc[cx.state_id_i] <= cx.data0_i;
        end
        CXU_CLEAR: begin
          resp_q <= acc[cx.state_id_i];
          stat_q <= '0;
          acc[cx.state_id_i] <= '0;
        end
        default: begin
          resp_q <= '0;
          stat_q <= ST_ILLEGAL;
        end
      endcase
    end else if (mul_done) begin
      stat_q <= mul_stat;
      if (func_q == CXU_MAC) begin
        acc[sid_q] <= mac_sum[31:0];
        resp_q     <= mac_sum[31:0];
      end else begin
        resp_q <= mul_prod;
      end
    end
  end

endmodule

// File: tb/tb_cxu_mac.sv
// tb_cxu_mac: directed + random checks of cxu_mac against a behavioural model.
// Model uses 64-bit products and a plain accumulator array.
module tb_cxu_mac;
  import cx_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [31:0] m_acc [4];

  always #5 clk = ~clk;

  cxu_mac_if cx();

  cxu_mac #(
    .N_STATES  (4),
    .EARLY_TERM(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cx (cx)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int iters(input logic [31:0] b);
    int k;
    k = 1;
    for (int i = 0; i < 32; i++) if (b[i]) k = i + 1;
    return k;
  endfunction

  task automatic model(input logic [2:0] f, input logic [1:0] s,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] er, output logic [3:0] es,
                       output int el);
    logic [63:0] full;
    logic [32:0] sum;
    full = {32'd0, a} * {32'd0, b};
    sum  = {1'b0, m_acc[s]} + {1'b0, full[31:0]};
    el = 1;
    es = 4'b0000;
    case (f)
      3'd0: begin
        er = full[31:0];
        es[2] = (full[63:32] != 0);
        el = iters(b) + 1;
      end
      3'd1: begin
        er = sum[31:0];
        es[2] = (full[63:32] != 0);
        es[1] = sum[32];
        m_acc[s] = sum[31:0];
        el = iters(b) + 1;
      end
      3'd2: er = m_acc[s];
      3'd3: begin er = m_acc[s]; m_acc[s] = a; end
      3'd4: begin er = m_acc[s]; m_acc[s] = 32'd0; end
      default: begin er = 32'd0; es = 4'b0001; end
    endcase
  endtask

  task automatic op(input logic [2:0] f, input logic [1:0] s,
                    input logic [31:0] a, input logic [31:0] b,
                    input int inj);
    logic [31:0] er;
    logic [3:0]  es;
    int el, lat, nb;
    bit got;
    model(f, s, a, b, er, es, el);
    cx.func_i = f;
    cx.state_id_i = s;
    cx.data0_i = a;
    cx.data1_i = b;
    cx.req_start_i = 1'b1;
    @(posedge clk); #1;
    cx.req_start_i = 1'b0;
    cx.func_i = 3'($urandom);
    cx.state_id_i = 2'($urandom);
    cx.data0_i = $urandom;
    cx.data1_i = $urandom;
    lat = 1; nb = 0; got = 1'b0;
    while (lat <= 40) begin
      if (cx.busy_o) nb++;
      if (cx.replying_o) begin got = 1'b1; break; end
      cx.req_start_i = (inj != 0 && lat == inj);
      @(posedge clk); #1;
      lat++;
    end
    cx.req_start_i = 1'b0;
    chk($sformatf("reply_seen f%0d", f), 64'(got), 64'd1);
    if (got) begin
      chk($sformatf("latency f%0d", f), 64'(lat), 64'(el));
      chk($sformatf("busy_cycles f%0d", f), 64'(nb), 64'(el));
      chk($sformatf("response f%0d", f), 64'(cx.response_o), 64'(er));
      chk($sformatf("status f%0d", f), 64'(cx.status_o), 64'(es));
      @(posedge clk); #1;
      chk("pulse_width", 64'(cx.replying_o), 64'd0);
      chk("resp_hold", 64'(cx.response_o), 64'(er));
    end
  endtask

  initial begin
    cx.req_start_i = 1'b0;
    cx.func_i = '0;
    cx.state_id_i = '0;
    cx.data0_i = '0;
    cx.data1_i = '0;
    for (int i = 0; i < 4; i++) m_acc[i] = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_replying", 64'(cx.replying_o), 64'd0);
    chk("rst_busy", 64'(cx.busy_o), 64'd0);
    chk("rst_response", 64'(cx.response_o), 64'd0);
    chk("rst_status", 64'(cx.status_o), 64'd0);

    op(CXU_MUL, 2'd0, 32'd7, 32'd6, 0);
    op(CXU_WRITE, 2'd2, 32'hFFFF_FFF0, 32'd0, 0);
    op(CXU_MAC, 2'd2, 32'd4, 32'd5, 0);
    op(CXU_READ, 2'd2, 32'd0, 32'd0, 0);
    op(CXU_READ, 2'd0, 32'd0, 32'd0, 0);
    op(CXU_MUL, 2'd1, 32'h0001_0000, 32'h0001_0000, 0);
    op(CXU_MUL, 2'd1, 32'h1234_5678, 32'd0, 0);
    op(3'd6, 2'd2, 32'hDEAD_BEEF, 32'd3, 0);
    for (int i = 0; i < 4; i++) op(CXU_READ, 2'(i), 32'd0, 32'd0, 0);

    op(CXU_WRITE, 2'd1, 32'd100, 32'd0, 0);
    op(CXU_MAC, 2'd1, 32'd3, 32'h8000_0000, 10);
    op(CXU_CLEAR, 2'd1, 32'd0, 32'd0, 0);
    op(CXU_READ, 2'd1, 32'd0, 32'd0, 0);

    op(CXU_WRITE, 2'd3, 32'd9, 32'd0, 0);
    cx.func_i = CXU_MAC;
    cx.state_id_i = 2'd3;
    cx.data0_i = 32'd3;
    cx.data1_i = 32'h0000_00FF;
    cx.req_start_i = 1'b1;
    @(posedge clk); #1;
    cx.req_start_i = 1'b0;
    repeat (3) begin
      chk("midop_no_reply", 64'(cx.replying_o), 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) m_acc[i] = 32'd0;
    chk("abort_busy", 64'(cx.busy_o), 64'd0);
    chk("abort_response", 64'(cx.response_o), 64'd0);
    chk("abort_status", 64'(cx.status_o), 64'd0);
    repeat (8) begin
      @(posedge clk); #1;
      chk("abort_no_reply", 64'(cx.replying_o), 64'd0);
    end
    op(CXU_READ, 2'd3, 32'd0, 32'd0, 0);

    for (int n = 0; n < 80; n++) begin
      logic [2:0]  f;
      logic [31:0] b;
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 2) != 0) f = 3'($urandom_range(0, 4));
      b = $urandom >> $urandom_range(0, 31);
      op(f, 2'($urandom), $urandom, b, 0);
    end
    for (int i = 0; i < 4; i++) op(CXU_READ, 2'(i), 32'd0, 32'd0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cxu_mac.md
Name: cxu_mac

Overview:
Stateful custom-function unit (CXU) that sits directly downstream of the CX switch. It consumes the switch's broadcast operands (data0, data1, state_id) plus a per-CXU start strobe. It returns a 32-bit response and a 4-bit status with a one-cycle replying pulse, which the switch samples while in REQ_IN_PROGRESS. It holds one 32-bit accumulator per CX state context and performs iterative shift-add multiply and multiply-accumulate, plus accumulator read, write and clear.

Parameters:
N_STATES, 4, number of accumulator contexts; fixed by the 2-bit state_id.
EARLY_TERM, 1, when 1, multiply stops once the remaining multiplier bits are zero; when 0, always runs 32 iterations.

Ports:
clk  in  1  unit clock; same domain as the switch.
rst  in  1  synchronous, active-high reset.
req_start_i  in  1  one-cycle start pulse, driven by integration as cx_req_valid & cx_req_ready & (cx_cxu_id == this CXU).
func_i  in  3  function code, sampled on start.
state_id_i  in  2  accumulator context, sampled on start.
data0_i  in  32  operand A (multiplicand / write value).
data1_i  in  32  operand B (multiplier).
replying_o  out  1  one-cycle pulse; response_o and status_o are valid in the same cycle. Maps to the CXU's bit of cxu_replying.
response_o  out  32  result; held until the next reply.
status_o  out  4  status; held until the next reply.
busy_o  out  1  high from the cycle after start until replying_o deasserts.

Behaviour:
- Reset (clk edge with rst=1): all outputs 0, all accumulators 0, FSM to IDLE. Reset mid-operation aborts the operation with no reply, and the target accumulator is cleared with the rest.
- FSM states: IDLE, BUSY, REPLY.
  - IDLE: on req_start_i, latch func, state_id, A, B.
    - Single-cycle functions go to REPLY.
    - MUL/MAC go to BUSY with product=0, mcand=A, mplier=B.
  - BUSY: each cycle, if mplier[0], product += mcand; then mcand <<= 1, mplier >>= 1 (32-bit, wrap).
    - Exit to REPLY after k iterations.
    - EARLY_TERM=1: k = max(1, position of highest set bit of B + 1).
    - EARLY_TERM=0: k = 32.
  - REPLY: replying_o=1 for exactly one cycle, then IDLE. Response/status registers update on entry to REPLY.
- Latency from the start-sampling edge to replying_o high:
  - single-cycle functions: 1 cycle;
  - MUL/MAC: k+1 cycles.
- Function codes:
  - 0 MUL: response = (A*B)[31:0]; accumulator untouched.
  - 1 MAC: acc[s] = acc[s] + (A*B)[31:0], mod 2^32; response = new acc[s]. Accumulator write happens on entry to REPLY.
  - 2 READ: response = acc[s].
  - 3 WRITE: acc[s] = A; response = old acc[s].
  - 4 CLEAR: acc[s] = 0; response = old acc[s].
  - 5-7: illegal; response = 0, no state change, latency 1.
- Status (bit flags, 0 = OK):
  - bit0: illegal function.
  - bit1: MAC add carry-out (unsigned overflow).
  - bit2: multiply product exceeded 32 bits (upper bits lost), MUL/MAC only. Computed from the iteration carry-outs and from any set mcand bits shifted out while mplier bits remain.
  - bit3: reserved, 0.
- req_start_i while BUSY or REPLY: ignored; no queueing, no error. The switch guarantees one outstanding request.
- Operand inputs are don't-care except on the start cycle.
- Only acc[state_id latched] is ever modified by an operation; other contexts are unaffected.

Decomposition:
- Shared package cx_pkg:
  - function code constants (CXU_MUL..CXU_CLEAR);
  - status bit positions;
  - FSM state typedef;
  - CX widths (data 32, status 4, state_id 2).
- One natural sub-module: cxu_mac_mulseq, the iterative shift-add multiplier datapath (start, A, B, done, product, overflow). The top keeps the FSM, the accumulator file and the reply registers.

Test Plan:
- Reset, then MUL A=7 B=6, EARLY_TERM=1 -> k=3; replying_o exactly 4 cycles after start, for one cycle; response=42, status=0; busy_o high for 4 cycles.
- WRITE s=2 A=0xFFFFFFF0 (response=0), then MAC s=2 A=4 B=5 -> response=0x00000004, status=4'b0010; READ s=2 -> 0x4; READ s=0 -> 0.
- MUL A=0x10000 B=0x10000 -> response=0, status=4'b0100; B=0 -> k=1, response=0, latency 2.
- func=6 -> replying_o 1 cycle after start, response=0, status=4'b0001; all accumulators unchanged.
- MAC s=1 with B=0x80000000 (k=32); pulse req_start_i at cycle 10 -> ignored; single reply at cycle 33. Then CLEAR s=1 -> returns prior acc, following READ returns 0.
- Start MAC s=3 after WRITE s=3 A=9; assert rst mid-BUSY -> no reply; after reset, READ s=3 returns 0 and response_o/status_o read 0 before the reply.
